// File: rtl/bbc_micro_via_timers_if.sv
// CPU-side register bus of the 6522 VIA timer block: chip select, direction,
// register select, write data and combinational read data.
interface bbc_micro_via_timers_if;
    logic       select;
    logic       read_not_write;
    logic [3:0] address;
    logic [7:0] write_data;
    logic [7:0] read_data;

    modport master (
        output select,
        output read_not_write,
        output address,
        output write_data,
        input  read_data
    );

    modport slave (
        input  select,
        input  read_not_write,
        input  address,
        input  write_data,
        output read_data
    );
endinterface

// File: rtl/bbc_micro_via_timers.sv
// 6522 VIA timer/interrupt core: T1 (one-shot/free-run with PB7), T2 (one-shot or
// PB6 pulse count), ACR, IFR, IER and the active-low IRQ, clocked by the 1MHz tick.
module bbc_micro_via_timers (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clock_control__enable_cpu,
    input  logic                         clock_control__enable_1MHz_falling,
    bbc_micro_via_timers_if.slave        bus,
    input  logic                         pb6_in,
    output logic                         irq_n,
    output logic                         pb7_out,
    output logic                         pb7_enable
);

    localparam logic [3:0] ADDR_T1C_L = 4'h4;
    localparam logic [3:0] ADDR_T1C_H = 4'h5;
    localparam logic [3:0] ADDR_T1L_L = 4'h6;
    localparam logic [3:0] ADDR_T1L_H = 4'h7;
    localparam logic [3:0] ADDR_T2C_L = 4'h8;
    localparam logic [3:0] ADDR_T2C_H = 4'h9;
    localparam logic [3:0] ADDR_ACR   = 4'hB;
    localparam logic [3:0] ADDR_IFR   = 4'hD;
    localparam logic [3:0] ADDR_IER   = 4'hE;

    logic        tick;
    logic        access;
    logic        write_access;
    logic        read_access;
    logic [3:0]  addr;
    logic [7:0]  wdata;

    logic [15:0] t1_counter;
    logic [15:0] t1_counter_next;
    logic [15:0] t1_latch;
    logic [15:0] t1_latch_next;
    logic        t1_armed;
    logic        t1_armed_next;
    logic        t1_load;
    logic        t1_fire;

    logic [15:0] t2_counter;
    logic [15:0] t2_counter_next;
    logic [7:0]  t2_latch_low;
    logic [7:0]  t2_latch_low_next;
    logic        t2_armed;
    logic        t2_armed_next;
    logic        t2_load;
    logic        t2_fire;
    logic        t2_decrement;

    logic [7:0]  acr;
    logic [7:0]  acr_next;
    logic [1:0]  ifr;
    logic [1:0]  ifr_next;
    logic [1:0]  ier;
    logic [1:0]  ier_next;

    logic        pb6_sync;
    logic        pb6_prev;
    logic        pb6_fall;
    logic        pb7_q;
    logic        pb7_next;
    logic        irq;

    assign tick         = clock_control__enable_1MHz_falling;
    assign access       = bus.select & clock_control__enable_cpu;
    assign write_access = access & ~bus.read_not_write;
    assign read_access  = access & bus.read_not_write;
    assign addr         = bus.address;
    assign wdata        = bus.write_data;

    assign t1_load  = write_access && (addr == ADDR_T1C_H);
    assign t2_load  = write_access && (addr == ADDR_T2C_H);
    assign pb6_fall = pb6_prev & ~pb6_sync;

    // A counter load on the same clk as a tick takes priority and suppresses the timeout.
    always_comb begin
        t1_counter_next = t1_counter;
        t1_armed_next   = t1_armed;
        pb7_next        = pb7_q;
        t1_fire         = 1'b0;
        if (t1_load) begin
            t1_counter_next = {wdata, t1_latch[7:0]};
            t1_armed_next   = 1'b1;
            if (acr[7]) begin
                pb7_next = 1'b0;
            end
        end else if (tick) begin
            if (t1_counter == 16'h0000) begin
                t1_fire = t1_armed;
                if (acr[6]) begin
                    t1_counter_next = t1_latch;
                    if (acr[7]) begin
                        pb7_next = ~pb7_q;
                    end
                end else begin
                    t1_counter_next = 16'hFFFF;
                    t1_armed_next   = 1'b0;
                    if (acr[7] && t1_armed) begin
                        pb7_next = 1'b1;
                    end
                end
            end else begin
                t1_counter_next = t1_counter - 16'd1;
            end
        end
    end

    always_comb begin
        t2_decrement    = acr[5] ? pb6_fall : tick;
        t2_counter_next = t2_counter;
        t2_armed_next   = t2_armed;
        t2_fire         = 1'b0;
        if (t2_load) begin
            t2_counter_next = {wdata, t2_latch_low};
            t2_armed_next   = 1'b1;
        end else if (t2_decrement) begin
            t2_counter_next = t2_counter - 16'd1;
            if (t2_counter == 16'h0000) begin
                t2_fire       = t2_armed;
                t2_armed_next = 1'b0;
            end
        end
    end

    always_comb begin
        t1_latch_next     = t1_latch;
        t2_latch_low_next = t2_latch_low;
        acr_next          = acr;
        ier_next          = ier;
        if (write_access) begin
            case (addr)
                ADDR_T1C_L, ADDR_T1L_L: t1_latch_next[7:0]  = wdata;
                ADDR_T1C_H, ADDR_T1L_H: t1_latch_next[15:8] = wdata;
                ADDR_T2C_L:             t2_latch_low_next   = wdata;
                ADDR_ACR:               acr_next            = wdata;
                ADDR_IER: begin
                    if (wdata[7]) begin
                        ier_next = ier | wdata[6:5];
                    end else begin
                        ier_next = ier & ~wdata[6:5];
                    end
                end
                default: ;
            endcase
        end
    end

    // Flag clears are applied first so that a timeout on the same clk still leaves the flag set.
    always_comb begin
        ifr_next = ifr;
        if (read_access && (addr == ADDR_T1C_L)) begin
            ifr_next[1] = 1'b0;
        end
        if (read_access && (addr == ADDR_T2C_L)) begin
            ifr_next[0] = 1'b0;
        end
        if (write_access) begin
            case (addr)
                ADDR_T1C_H, ADDR_T1L_H: ifr_next[1] = 1'b0;
                ADDR_T2C_H:             ifr_next[0] = 1'b0;
                ADDR_IFR:               ifr_next    = ifr & ~wdata[6:5];
                default: ;
            endcase
        end
        if (t1_fire) begin
            ifr_next[1] = 1'b1;
        end
        if (t2_fire) begin
            ifr_next[0] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            t1_counter   <= 16'h0000;
            t1_latch     <= 16'h0000;
            t1_armed     <= 1'b0;
            t2_counter   <= 16'h0000;
            t2_latch_low <= 8'h00;
            t2_armed     <= 1'b0;
            acr          <= 8'h00;
            ifr          <= 2'b00;
            ier          <= 2'b00;
            pb6_sync     <= 1'b1;
            pb6_prev     <= 1'b1;
            pb7_q        <= 1'b1;
        end else begin
            t1_counter   <= t1_counter_next;
            t1_latch     <= t1_latch_next;
            t1_armed     <= t1_armed_next;
            t2_counter   <= t2_counter_next;
            t2_latch_low <= t2_latch_low_next;
            t2_armed     <= t2_armed_next;
            acr          <= acr_next;
            ifr          <= ifr_next;
            ier          <= ier_next;
            pb6_sync     <= pb6_in;
            pb6_prev     <= pb6_sync;
            pb7_q        <= pb7_next;
        end
    end

    assign irq        = |(ifr & ier);
    assign irq_n      = ~irq;
    assign pb7_out    = pb7_q;
    assign pb7_enable = acr[7];

    always_comb begin
        bus.read_data = 8'h00;
        if (bus.select) begin
            case (addr)
                ADDR_T1C_L: bus.read_data = t1_counter[7:0];
                ADDR_T1C_H: bus.read_data = t1_counter[15:8];
                ADDR_T1L_L: bus.read_data = t1_latch[7:0];
                ADDR_T1L_H: bus.read_data = t1_latch[15:8];
                ADDR_T2C_L: bus.read_data = t2_counter[7:0];
                ADDR_T2C_H: bus.read_data = t2_counter[15:8];
                ADDR_ACR:   bus.read_data = acr;
                ADDR_IFR:   bus.read_data = {irq, ifr, 5'b00000};
                ADDR_IER:   bus.read_data = {1'b1, ier, 5'b00000};
                default:    bus.read_data = 8'h00;
            endcase
        end
    end

endmodule
